// File: rtl/determ_decode_fxp.sv
// Deterministic bitstream (1 = +1, 0 = -1) to signed fixed-point decoder over a 2^LOG_WIN window.
// Optional synchronous window clear port clr is enabled by defining DETERM_DECODE_CLR_EN.
module determ_decode_fxp #(
   parameter int BIT_WIDTH = 16,
   parameter int FRAC_BITS = 14,
   parameter int LOG_WIN   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
`ifdef DETERM_DECODE_CLR_EN
   input  logic                        clr,
`endif
   input  logic                        a,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic signed [BIT_WIDTH-1:0] y,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int W     = 1 << LOG_WIN;
   localparam int SHIFT = FRAC_BITS - LOG_WIN;

   logic [LOG_WIN-1:0]          bitcnt_reg, bitcnt_next;
   logic [LOG_WIN:0]            onescnt_reg, onescnt_next;
   logic signed [BIT_WIDTH-1:0] y_reg, y_next;
   logic                        out_valid_reg, out_valid_next;

   logic                        clr_int;
   logic                        accept;
   logic                        last_bit;
   logic [LOG_WIN:0]            ones_total;
   logic signed [LOG_WIN+1:0]   diff;
   logic signed [BIT_WIDTH-1:0] diff_ext;
   logic signed [BIT_WIDTH-1:0] result;

`ifdef DETERM_DECODE_CLR_EN
   assign clr_int = clr;
`else
   assign clr_int = 1'b0;
`endif

   assign last_bit = (bitcnt_reg == LOG_WIN'(W - 1));
   // Only the final bit of a window can be stalled, and only while a result is still unconsumed.
   assign in_ready = !(out_valid_reg && !out_ready && last_bit);
   assign accept   = in_valid && in_ready;

   assign ones_total = onescnt_reg + (LOG_WIN+1)'(a);
   // 2*c - W always fits LOG_WIN+2 signed bits since c is in 0..W.
   assign diff       = $signed({1'b0, ones_total} << 1) - $signed((LOG_WIN+2)'(W));
   assign diff_ext   = {{(BIT_WIDTH-LOG_WIN-2){diff[LOG_WIN+1]}}, diff};
   assign result     = diff_ext <<< SHIFT;

   always_comb begin
      bitcnt_next    = bitcnt_reg;
      onescnt_next   = onescnt_reg;
      y_next         = y_reg;
      out_valid_next = out_valid_reg;

      if (out_valid_reg && out_ready)
         out_valid_next = 1'b0;

      if (clr_int) begin
         bitcnt_next  = '0;
         onescnt_next = '0;
      end else if (accept) begin
         if (last_bit) begin
            y_next         = result;
            out_valid_next = 1'b1;
            bitcnt_next    = '0;
            onescnt_next   = '0;
         end else begin
            bitcnt_next  = bitcnt_reg + LOG_WIN'(1);
            onescnt_next = ones_total;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitcnt_reg    <= '0;
         onescnt_reg   <= '0;
         y_reg         <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         bitcnt_reg    <= bitcnt_next;
         onescnt_reg   <= onescnt_next;
         y_reg         <= y_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign y         = y_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_determ_decode_fxp.sv
// Self-checking bench for determ_decode_fxp: directed windows, backpressure, reset and random traffic
// against a window-list reference model.
module tb_determ_decode_fxp;

   localparam int BIT_WIDTH = 16;
   localparam int FRAC_BITS = 14;
   localparam int LOG_WIN   = 4;
   localparam int W         = 1 << LOG_WIN;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic                        clr = 1'b0;
   logic                        a = 1'b0;
   logic                        in_valid = 1'b0;
   logic                        in_ready;
   logic signed [BIT_WIDTH-1:0] y;
   logic                        out_valid;
   logic                        out_ready = 1'b0;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit                          win_q[$];
   bit                          pend = 1'b0;
   logic [BIT_WIDTH-1:0]        yexp = '0;

   determ_decode_fxp #(
      .BIT_WIDTH(BIT_WIDTH),
      .FRAC_BITS(FRAC_BITS),
      .LOG_WIN  (LOG_WIN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef DETERM_DECODE_CLR_EN
      .clr      (clr),
`endif
      .a        (a),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y        (y),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; the model tracks the window as a list of accepted bits.
   task automatic step(input bit v, input bit ab, input bit ordy, input bit c);
      bit exp_rdy;
      int ones;
      @(negedge clk);
      in_valid = v; a = ab; out_ready = ordy; clr = c;
      #1;
      exp_rdy = !(pend && !ordy && win_q.size() == W - 1);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (pend && ordy) pend = 1'b0;
`ifdef DETERM_DECODE_CLR_EN
      if (c) win_q.delete();
      else
`endif
      if (v && exp_rdy) begin
         win_q.push_back(ab);
         if (win_q.size() == W) begin
            ones = 0;
            foreach (win_q[i]) ones += int'(win_q[i]);
            yexp = BIT_WIDTH'((2 * ones - W) * (1 << (FRAC_BITS - LOG_WIN)));
            pend = 1'b1;
            win_q.delete();
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", {31'd0, out_valid}, {31'd0, pend});
      check("y", {16'd0, y}, {16'd0, yexp});
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      win_q.delete();
      pend = 1'b0;
      yexp = '0;
      check("rst_y", {16'd0, y}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit pat[16];
      int j;
      bit t;

      // power-on reset
      #1;
      check("por_y", {16'd0, y}, 32'd0);
      check("por_out_valid", {31'd0, out_valid}, 32'd0);
      check("por_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // all ones -> +1.0, single-cycle out_valid
      for (int i = 0; i < W; i++) step(1, 1, 1, 0);
      check("ones_y", {16'd0, y}, 32'h4000);
      check("ones_ov", {31'd0, out_valid}, 32'd1);
      step(0, 0, 1, 0);
      check("ones_ov_drop", {31'd0, out_valid}, 32'd0);

      // all zeros -> -1.0
      for (int i = 0; i < W; i++) step(1, 0, 1, 0);
      check("zeros_y", {16'd0, y}, 32'hC000);

      // alternating -> 0
      for (int i = 0; i < W; i++) step(1, (i % 2) == 0, 1, 0);
      check("alt_y", {16'd0, y}, 32'h0000);
      step(0, 1, 1, 0);

      // 12 ones + 4 zeros shuffled, with in_valid gaps -> +0.5
      foreach (pat[i]) pat[i] = (i < 12);
      for (int i = W - 1; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = pat[i]; pat[i] = pat[j]; pat[j] = t;
      end
      for (int i = 0; i < W; i++) begin
         repeat ($urandom_range(2, 0)) step(0, $urandom_range(1, 0), 1, 0);
         step(1, pat[i], 1, 0);
         if (i < W - 1) check("mix_no_early", {31'd0, out_valid}, 32'd0);
      end
      check("mix_y", {16'd0, y}, 32'h2000);
      step(0, 0, 1, 0);

      // backpressure: two windows back-to-back with out_ready low
      for (int i = 0; i < W; i++) step(1, 1, 0, 0);
      for (int i = 0; i < W - 1; i++) step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("bp_stall_rdy", {31'd0, in_ready}, 32'd0);
      check("bp_hold_y", {16'd0, y}, 32'h4000);
      step(1, 0, 1, 0);
      check("bp_second_ov", {31'd0, out_valid}, 32'd1);
      check("bp_second_y", {16'd0, y}, 32'hC000);
      step(0, 0, 1, 0);

      // reset mid-window, then a clean window
      for (int i = 0; i < 7; i++) step(1, $urandom_range(1, 0), 1, 0);
      do_reset();
      for (int i = 0; i < W; i++) step(1, 1, 1, 0);
      check("post_rst_y", {16'd0, y}, 32'h4000);
      step(0, 0, 1, 0);

`ifdef DETERM_DECODE_CLR_EN
      for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
      step(0, 0, 1, 1);
      for (int i = 0; i < W; i++) step(1, 1, 1, 0);
      check("clr_y", {16'd0, y}, 32'h4000);
      step(0, 0, 1, 0);
      for (int i = 0; i < W - 1; i++) step(1, 0, 1, 0);
      step(1, 0, 1, 1);
      check("clr_last_ov", {31'd0, out_valid}, 32'd0);
`endif

      // random traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(9, 0) < 7, $urandom_range(1, 0), $urandom_range(9, 0) < 5,
`ifdef DETERM_DECODE_CLR_EN
              $urandom_range(49, 0) == 0
`else
              1'b0
`endif
              );

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/determ_decode_fxp.md
Name: determ_decode_fxp

Overview:
- Converts a deterministic bitstream (1 = +1, 0 = -1) back into a signed fixed-point value.
- Averages the bitstream over a fixed window of 2^LOG_WIN accepted bits.
- Sits at the output end of deterministic-bitstream datapaths, after the bitstream multipliers and adders, and returns results to the FXP domain.
- Uses a valid/ready handshake on both input and output so it can stall under downstream backpressure.

Parameters:
- BIT_WIDTH, 16: width of signed output y.
- FRAC_BITS, 14: fractional bits of y; +1.0 = 2^FRAC_BITS. Constraints: BIT_WIDTH >= FRAC_BITS + 2 and FRAC_BITS >= LOG_WIN.
- LOG_WIN, 4: log2 of window length W = 2^LOG_WIN bits.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- a  input  1  bitstream bit (1 = +1, 0 = -1).
- in_valid  input  1  a is valid this cycle.
- in_ready  output  1  block accepts a this cycle.
- y  output  BIT_WIDTH  signed decoded value.
- out_valid  output  1  y holds an unconsumed result.
- out_ready  input  1  downstream consumes y this cycle.

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous and active-high.
- Reset values: y = 0, out_valid = 0, bit counter = 0, ones counter = 0. in_ready = 1 immediately after reset.
- Input accept: a bit is accepted when in_valid && in_ready at a CLK rising edge. Counters change only on accept.
- Counters:
  - bit counter: LOG_WIN bits, counts 0..W-1, wraps to 0 after W-1.
  - ones counter: LOG_WIN+1 bits, counts accepted 1s in the current window, range 0..W.
- Window completion: occurs on the accept where bit counter == W-1. On that edge:
  - y <= (2*c - W) << (FRAC_BITS - LOG_WIN), where c = ones count including the bit just accepted.
  - out_valid <= 1.
  - Both counters <= 0, so the next accept starts a fresh window with no bubble.
- Arithmetic: 2*c - W is signed LOG_WIN+2 bits, sign-extended to BIT_WIDTH before the shift. The result lies in [-2^FRAC_BITS, +2^FRAC_BITS]; no saturation is needed or applied.
- Latency: y and out_valid update on the same edge that accepts the W-th bit, i.e. visible 1 cycle after that bit is presented.
- Output handshake:
  - out_valid stays high and y stays stable until out_valid && out_ready at an edge; then out_valid <= 0, unless a new window completes on that same edge, in which case out_valid stays 1 and y loads the new result.
  - y keeps its last value after consumption.
- Backpressure: in_ready = !(out_valid && !out_ready && bitcount == W-1).
  - An unconsumed result is never overwritten.
  - Non-final bits are always accepted while the output is held.
  - in_ready is combinational from out_ready and registered state.
- in_valid low: counters hold; a partial window is retained indefinitely.
- Reset mid-window: the partial window is discarded and a pending result is dropped (out_valid = 0).
- Values of a while in_valid is low are ignored.

Optional Feature:
- Macro: DETERM_DECODE_CLR_EN.
- Defined: adds input port clr (1 bit, synchronous, active-high).
  - When clr = 1 at an edge: both counters <= 0 and any bit accepted that cycle is discarded.
  - in_ready still evaluates normally; out_valid and y are unaffected.
  - clr on a window-completing edge: the completion is suppressed, and y/out_valid are not updated by that window.
- Undefined: no clr port; windows are aborted only by RST.

Test Plan (BIT_WIDTH=16, FRAC_BITS=14, LOG_WIN=4, W=16):
- 16 accepted 1s, out_ready=1 -> after 16th bit, y=16384 (0x4000), out_valid=1 for exactly 1 cycle.
- 16 accepted 0s -> y=-16384 (0xC000); alternating 1,0 x8 -> y=0.
- 12 ones + 4 zeros in random order, with in_valid gaps -> y=8192 (+0.5), emitted after the 16th accepted bit only.
- out_ready=0, two windows streamed back-to-back -> first result held, in_ready=0 on the 32nd bit. Raise out_ready -> first y consumed, second window completes on that same edge, out_valid stays 1, y=second value.
- RST asserted after 7 bits of a window, then 16 ones -> y=16384 on the first post-reset window; no partial-window contamination; outputs 0 during reset.
- With DETERM_DECODE_CLR_EN: 5 zeros, clr pulse, then 16 ones -> y=16384. clr on the 16th bit -> no out_valid for that window.
